ysyx_23060072_pc_fetch: RTL and testbench
=========================================

YSYX_23060072_PC_FETCH -- requirements
Module: ysyx_23060072_pc_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h8000_0000, first fetch address after reset.
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid_o  output  1  fetch request valid to instruction memory.
- req_addr_o  output  32  fetch address, always word-aligned.
- req_ready_i  input  1  memory accepts request.
- rsp_valid_i  input  1  instruction word returned; no back-pressure.
- rsp_data_i  input  32  returned instruction word.
- if_valid_o  output  1  instruction valid to decode.
- if_pc_o  output  32  PC of presented instruction.
- if_instr_o  output  32  presented instruction word.
- if_ready_i  input  1  decode accepts instruction.
- redirect_i  input  1  branch/jump redirect, one-cycle pulse.
- redirect_pc_i  input  32  redirect target; bits [1:0] ignored.

Function
REQ-003 SHALL use two states: S_REQ (may issue) and S_WAIT (one request outstanding); never more than one request outstanding.
REQ-004 SHALL hold a fetch PC register (next address), a pending-PC register (address of outstanding request), a one-entry output buffer (valid, pc, instr) and a kill flag.
REQ-005 In S_REQ, req_valid_o SHALL be 1 iff buffer empty or (if_valid_o and if_ready_i); req_addr_o = fetch PC.
REQ-006 Request handshake (req_valid_o & req_ready_i) SHALL copy fetch PC to pending-PC, add 4 to fetch PC (mod 2^32, wrap 0xFFFF_FFFC -> 0x0000_0000) and move to S_WAIT.
REQ-007 In S_WAIT, req_valid_o SHALL be 0; rsp_valid_i with kill=0 SHALL load buffer {1, pending-PC, rsp_data_i} and return to S_REQ, so if_valid_o rises the cycle after the response.
REQ-008 rsp_valid_i in S_WAIT with kill=1 SHALL discard the data, clear kill, return to S_REQ; rsp_valid_i in S_REQ SHALL be ignored.
REQ-009 Buffer SHALL clear on if_valid_o & if_ready_i unless reloaded the same cycle; if_pc_o/if_instr_o SHALL hold stable while if_valid_o=1 and if_ready_i=0.
REQ-010 Redirect has priority over every other event: fetch PC <= {redirect_pc_i[31:2],2'b00}, buffer valid <= 0 next cycle.
REQ-011 Redirect in S_WAIT without rsp_valid_i SHALL set kill; redirect coincident with rsp_valid_i SHALL discard that response and go to S_REQ.
REQ-012 Redirect coincident with a request handshake SHALL let the old-address request complete as killed (S_WAIT, kill=1); fetch PC still takes the redirect target.
REQ-013 req_addr_o SHALL change while req_valid_o=1 and req_ready_i=0 only on redirect.
REQ-014 Decode back-pressure SHALL block new requests only as per REQ-005; it SHALL NOT affect an outstanding request.

Reset
REQ-015 rst_n=0 SHALL asynchronously force: state S_REQ, fetch PC=RESET_PC, pending-PC=0, kill=0, buffer valid=0, if_pc_o=0, if_instr_o=0.
REQ-016 First cycle after reset release, req_valid_o=1 with req_addr_o=32'h8000_0000.
REQ-017 Reset asserted mid-S_WAIT SHALL abandon the outstanding request; a late rsp_valid_i after release in S_REQ SHALL be ignored.

Verification
REQ-018 Zero-wait memory (ready=1, rsp one cycle later), if_ready_i=1 -> if_pc_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, one instruction per 2 cycles, data matches ROM.
REQ-019 if_ready_i=0 for 5 cycles with 0x8000_0004 buffered -> if_valid_o, if_pc_o=0x8000_0004, if_instr_o stable; req_valid_o=0; release -> fetch resumes at 0x8000_0008.
REQ-020 Redirect to 0x8000_0103 while request 0x8000_0010 outstanding, rsp 3 cycles later -> response discarded, next req_addr_o=0x8000_0100, no if_valid_o for 0x8000_0010.
REQ-021 Redirect same cycle as rsp_valid_i and same cycle as request handshake -> both old instructions dropped, first delivered if_pc_o = target.
REQ-022 Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-023 rst_n low for one cycle mid-S_WAIT, stray rsp_valid_i after release -> if_valid_o stays 0, req_addr_o=0x8000_0000.

Source files
------------

// File: rtl/ysyx_23060072_pc_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_pc_fetch
//   Instruction fetch stage: issues word-aligned fetch requests to
//   instruction memory (at most one outstanding), captures the returned
//   word in a one-entry buffer and presents it to decode. A redirect
//   restarts fetch at a new target and drops any in-flight instruction.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid_o/_addr_o fetch request to memory, address word-aligned
//   req_ready_i         memory accepts request
//   rsp_valid_i/_data_i returned instruction word (no back-pressure)
//   if_valid_o/_pc_o/_instr_o  instruction presented to decode
//   if_ready_i          decode accepts instruction
//   redirect_i/_pc_i    one-cycle redirect pulse and target (bits [1:0] ignored)
// ---------------------------------------------------------------------------
module ysyx_23060072_pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  input  logic        if_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  typedef enum logic {
    S_REQ,
    S_WAIT
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pend_pc;
  logic        r_kill;
  logic        r_buf_valid;
  logic [31:0] r_buf_pc;
  logic [31:0] r_buf_instr;

  logic        w_out_fire;
  logic        w_req_fire;
  logic        w_rsp_take;
  logic [31:0] w_redirect_pc;
  logic        w_unused;

  // Low target bits are dropped so every fetch stays word-aligned.
  assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
  assign w_unused      = ^redirect_pc_i[1:0];

  assign w_out_fire  = r_buf_valid & if_ready_i;
  // A new request is only issued if its result has somewhere to land:
  // the buffer is empty, or it is being drained this very cycle.
  assign req_valid_o = (r_state == S_REQ) & (~r_buf_valid | w_out_fire);
  assign req_addr_o  = r_fetch_pc;
  assign w_req_fire  = req_valid_o & req_ready_i;
  // Responses are only meaningful while a request is outstanding.
  assign w_rsp_take  = (r_state == S_WAIT) & rsp_valid_i;

  assign if_valid_o  = r_buf_valid;
  assign if_pc_o     = r_buf_pc;
  assign if_instr_o  = r_buf_instr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_REQ;
      r_fetch_pc  <= RESET_PC;
      r_pend_pc   <= '0;
      r_kill      <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_pc    <= '0;
      r_buf_instr <= '0;
    end else begin
      if (redirect_i) begin
        r_fetch_pc <= w_redirect_pc;
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      if (w_req_fire) begin
        r_pend_pc <= r_fetch_pc;
      end

      // A request accepted in the redirect cycle belongs to the old
      // path; it still has to complete, but is marked killed.
      if (r_state == S_REQ) begin
        if (w_req_fire) begin
          r_state <= S_WAIT;
          r_kill  <= redirect_i;
        end
      end else begin
        if (rsp_valid_i) begin
          r_state <= S_REQ;
          r_kill  <= 1'b0;
        end else if (redirect_i) begin
          r_kill  <= 1'b1;
        end
      end

      // Redirect wins over both a fresh load and a drain.
      if (redirect_i) begin
        r_buf_valid <= 1'b0;
      end else if (w_rsp_take && !r_kill) begin
        r_buf_valid <= 1'b1;
        r_buf_pc    <= r_pend_pc;
        r_buf_instr <= rsp_data_i;
      end else if (w_out_fire) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060072_pc_fetch.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060072_pc_fetch. The bench plays instruction memory
// (ROM content is a hash of the address) and decode, and keeps a
// transaction-level model: the expected next request address, the single
// outstanding request with its killed flag, the presented instruction and
// the expected program-order PC stream.
// ---------------------------------------------------------------------------
module tb_ysyx_23060072_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i = 1'b0;
  logic        rsp_valid_i = 1'b0;
  logic [31:0] rsp_data_i = '0;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        if_ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;

  ysyx_23060072_pc_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_o  (req_valid_o),
    .req_addr_o   (req_addr_o),
    .req_ready_i  (req_ready_i),
    .rsp_valid_i  (rsp_valid_i),
    .rsp_data_i   (rsp_data_i),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_instr_o   (if_instr_o),
    .if_ready_i   (if_ready_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_deliv = 0;

  // model state
  bit          m_pend;
  bit          m_killed;
  logic [31:0] m_addr;
  int unsigned m_cnt;
  bit          m_out_valid;
  logic [31:0] m_out_pc;
  logic [31:0] m_next_addr;
  logic [31:0] m_stream;

  logic [31:0] hs_log[$];
  logic [31:0] dl_pc[$];
  int          dl_cyc[$];

  logic        s_req_valid, s_if_valid;
  logic [31:0] s_req_addr, s_if_pc, s_if_instr;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_killed = 0; m_cnt = 0; m_addr = '0;
    m_out_valid = 0; m_out_pc = '0;
    m_next_addr = 32'h8000_0000;
    m_stream    = 32'h8000_0000;
    hs_log.delete(); dl_pc.delete(); dl_cyc.delete();
  endtask

  // Called at a negedge; asserts reset asynchronously for one clock edge.
  task automatic do_reset();
    rsp_valid_i = 0; redirect_i = 0; req_ready_i = 0; if_ready_i = 0;
    #2 rst_n = 0;
    #1;
    chk("rst_if_valid", {31'b0, if_valid_o}, 32'd0);
    chk("rst_if_pc", if_pc_o, 32'd0);
    chk("rst_if_instr", if_instr_o, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    #1;
    chk("post_rst_req_valid", {31'b0, req_valid_o}, 32'd1);
    chk("post_rst_req_addr", req_addr_o, 32'h8000_0000);
  endtask

  // One clock cycle: drive inputs, compare outputs against the model,
  // then advance the model across the coming rising edge.
  task automatic cycle(input bit rdy, input bit ifrdy, input bit redir,
                       input logic [31:0] tgt, input bit stray, input int unsigned lat);
    bit rsp_now, deliver, fire, hs, exp_rv;
    rsp_now = m_pend && (m_cnt == 1);
    req_ready_i = rdy; if_ready_i = ifrdy;
    redirect_i = redir; redirect_pc_i = tgt;
    if (rsp_now) begin
      rsp_valid_i = 1; rsp_data_i = rom(m_addr);
    end else if (stray && !m_pend) begin
      rsp_valid_i = 1; rsp_data_i = rom(m_next_addr) ^ 32'hDEAD_BEEF;
    end else begin
      rsp_valid_i = 0; rsp_data_i = $urandom;
    end
    #1;
    s_req_valid = req_valid_o; s_req_addr = req_addr_o;
    s_if_valid = if_valid_o; s_if_pc = if_pc_o; s_if_instr = if_instr_o;

    exp_rv = !m_pend && (!m_out_valid || ifrdy);
    chk("if_valid", {31'b0, s_if_valid}, {31'b0, m_out_valid});
    if (m_out_valid) begin
      chk("if_pc", s_if_pc, m_out_pc);
      chk("if_instr", s_if_instr, rom(m_out_pc));
    end
    chk("req_valid", {31'b0, s_req_valid}, {31'b0, exp_rv});
    if (exp_rv) chk("req_addr", s_req_addr, m_next_addr);

    fire = m_out_valid && ifrdy;
    if (fire) begin
      chk("stream_pc", s_if_pc, m_stream);
      dl_pc.push_back(m_out_pc); dl_cyc.push_back(cyc);
      m_stream = m_stream + 32'd4;
      n_deliv++;
    end

    hs = exp_rv && rdy;
    deliver = 0;
    if (rsp_now) begin
      deliver = !m_killed && !redir;
      m_pend = 0;
    end
    if (m_pend) m_cnt--;
    if (redir) m_out_valid = 0;
    else if (deliver) begin m_out_valid = 1; m_out_pc = m_addr; end
    else if (fire) m_out_valid = 0;
    if (hs) begin
      m_pend = 1; m_addr = m_next_addr; m_cnt = lat; m_killed = redir;
      hs_log.push_back(m_next_addr);
      m_next_addr = m_next_addr + 32'd4;
    end
    if (redir) begin
      m_next_addr = {tgt[31:2], 2'b00};
      m_stream    = {tgt[31:2], 2'b00};
      if (m_pend) m_killed = 1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    logic [31:0] held;
    bit found;
    int start_deliv;
    @(negedge clk);
    do_reset();

    // Zero-wait memory, decode always ready.
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 32'd0, 0, 1);
    chk("seq_pc0", dl_pc[0], 32'h8000_0000);
    chk("seq_pc1", dl_pc[1], 32'h8000_0004);
    chk("seq_pc2", dl_pc[2], 32'h8000_0008);
    chk("seq_spacing", dl_cyc[1] - dl_cyc[0], 32'd2);

    // Decode stall with 0x8000_0004 buffered.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 32'd0, 0, 1);
    held = '0;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 32'd0, 0, 1);
      chk("stall_valid", {31'b0, s_if_valid}, 32'd1);
      chk("stall_pc", s_if_pc, 32'h8000_0004);
      chk("stall_req_valid", {31'b0, s_req_valid}, 32'd0);
      if (i == 0) held = s_if_instr;
      else chk("stall_instr", s_if_instr, held);
    end
    cycle(1, 1, 0, 32'd0, 0, 1);
    chk("resume_addr", hs_log[hs_log.size()-1], 32'h8000_0008);

    // Redirect while 0x8000_0010 is outstanding, response 3 cycles later.
    do_reset();
    for (int i = 0; i < 20; i++)
      cycle(1, 1, i == 9, 32'h8000_0103, 0, (i == 8) ? 4 : 1);
    chk("c_killed_addr", hs_log[4], 32'h8000_0010);
    chk("c_next_req", hs_log[5], 32'h8000_0100);
    found = 0;
    foreach (dl_pc[k]) if (dl_pc[k] == 32'h8000_0010) found = 1;
    chk("c_no_killed_delivery", {31'b0, found}, 32'd0);
    chk("c_first_after", dl_pc[4], 32'h8000_0100);

    // Redirect with response, then redirect with handshake.
    do_reset();
    for (int i = 0; i < 8; i++)
      cycle(1, 1, (i == 1) || (i == 2), (i == 1) ? 32'h8000_0200 : 32'h8000_0300, 0, 1);
    chk("d_hs1", hs_log[1], 32'h8000_0200);
    chk("d_hs2", hs_log[2], 32'h8000_0300);
    chk("d_first_deliv", dl_pc[0], 32'h8000_0300);

    // Wrap at the top of the address space.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 1, i == 0, 32'hFFFF_FFFE, 0, 1);
    chk("e_hs_top", hs_log[1], 32'hFFFF_FFFC);
    chk("e_hs_wrap", hs_log[2], 32'h0000_0000);
    chk("e_dl_top", dl_pc[0], 32'hFFFF_FFFC);
    chk("e_dl_wrap", dl_pc[1], 32'h0000_0000);

    // Reset mid-wait, stray response after release.
    do_reset();
    cycle(1, 1, 0, 32'd0, 0, 3);
    cycle(1, 1, 0, 32'd0, 0, 3);
    do_reset();
    cycle(0, 1, 0, 32'd0, 1, 1);
    cycle(0, 1, 0, 32'd0, 0, 1);
    chk("f_if_valid", {31'b0, s_if_valid}, 32'd0);
    chk("f_req_addr", s_req_addr, 32'h8000_0000);

    // Randomized traffic.
    do_reset();
    start_deliv = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      if ($urandom_range(299, 0) == 0) do_reset();
      tgt = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 7,
            $urandom_range(19, 0) == 0, tgt, $urandom_range(9, 0) == 0,
            $urandom_range(4, 1));
    end
    chk("rand_progress", {31'b0, (n_deliv - start_deliv) > 100}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
